// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder: sums two WIDTH-bit operands CHUNK bits per clock with a start/busy/done handshake.
// Optional macro ADD_SUB_EN adds a subtract mode (input sub) and signed-overflow flag (output ovf).
module chunk_serial_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADD_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q, partial, partial_nx;
    logic [WIDTH-1:0] b_in;
    logic             carry_q, c_in;
    logic [CW-1:0]    cnt;
    logic [CHUNK:0]   csum;
    logic             last, load;

    // Subtraction is a + ~b + 1, so invert B and force the carry at capture time.
`ifdef ADD_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign last = (cnt == CW'(NCHUNK - 1));

    always_comb begin
        csum = {1'b0, a_q[int'(cnt)*CHUNK +: CHUNK]}
             + {1'b0, b_q[int'(cnt)*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, carry_q};
        partial_nx = partial;
        partial_nx[int'(cnt)*CHUNK +: CHUNK] = csum[CHUNK-1:0];
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN:     if (last) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Result registers move only on the completing edge so partial sums never leak out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            partial <= '0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef ADD_SUB_EN
            ovf     <= 1'b0;
`endif
        end else if (load) begin
            a_q     <= a;
            b_q     <= b_in;
            carry_q <= c_in;
            cnt     <= '0;
            partial <= '0;
        end else if (state == RUN) begin
            partial <= partial_nx;
            carry_q <= csum[CHUNK];
            cnt     <= cnt + CW'(1);
            if (last) begin
                sum  <= partial_nx;
                cout <= csum[CHUNK];
`ifdef ADD_SUB_EN
                ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (partial_nx[WIDTH-1] != a_q[WIDTH-1]);
`endif
            end
        end
    end

endmodule
